// File: rtl/load_store_unit_if.sv
// Bus bundle between the core, the load/store unit and the data memory.
// The slave modport is the load/store unit. The master modport is the
// environment: the core request side plus the data-memory side.
interface load_store_unit_if;
  // core request side
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  // data memory side
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  modport slave (
    input  req, we, funct3, addr, wdata, mem_RD,
    output busy, done, rdata, err, mem_A, mem_WD, mem_WE
  );

  modport master (
    output req, we, funct3, addr, wdata, mem_RD,
    input  busy, done, rdata, err, mem_A, mem_WD, mem_WE
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide, single-port data memory.
// Sub-word stores are done as a read-modify-write, so every memory write
// is a full word. The optional misaligned-access check is enabled by
// defining LSU_MISALIGN_CHECK_EN. With the check disabled, halfword
// accesses ignore addr[0] and word accesses ignore addr[1:0].
module load_store_unit (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  // only the low halfword of the store data is needed after accept; a full
  // word store copies wdata straight into mem_wd at accept time
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        mem_we_q, mem_we_d;
  logic        illegal_s;
  logic        misalign_s;

  // funct3 codes that are not valid for the requested direction
  function automatic logic illegal_f3(input logic is_store, input logic [2:0] f3);
    logic bad;
    bad = 1'b0;
    if (is_store) begin
      case (f3)
        3'b000, 3'b001, 3'b010: bad = 1'b0;
        default:                bad = 1'b1;
      endcase
    end else begin
      case (f3)
        3'b011, 3'b110, 3'b111: bad = 1'b1;
        default:                bad = 1'b0;
      endcase
    end
    return bad;
  endfunction

  // pick the addressed byte/halfword out of a word and extend it
  function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                               input logic [1:0] a,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // replace the addressed byte/halfword of the old word with store data
  function automatic logic [31:0] store_merge(input logic [2:0]  f3,
                                              input logic [1:0]  a,
                                              input logic [31:0] old_w,
                                              input logic [15:0] wd);
    logic [31:0] r;
    r = old_w;
    case (f3[1:0])
      2'b00: begin
        case (a)
          2'b00:   r[7:0]   = wd[7:0];
          2'b01:   r[15:8]  = wd[7:0];
          2'b10:   r[23:16] = wd[7:0];
          default: r[31:24] = wd[7:0];
        endcase
      end
      2'b01: begin
        if (a[1]) begin
          r[31:16] = wd;
        end else begin
          r[15:0] = wd;
        end
      end
      default: r = old_w;
    endcase
    return r;
  endfunction

  // classify the incoming request: bad size code or misaligned address
  always_comb begin
    illegal_s  = illegal_f3(bus.we, bus.funct3);
`ifdef LSU_MISALIGN_CHECK_EN
    case (bus.funct3[1:0])
      2'b01:   misalign_s = bus.addr[0];
      2'b10:   misalign_s = (bus.addr[1:0] != 2'b00);
      default: misalign_s = 1'b0;
    endcase
`else
    misalign_s = 1'b0;
`endif
  end

  // next-state and next-output logic; outputs are registered from next state
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    mem_wd_d = mem_wd_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          we_d     = bus.we;
          funct3_d = bus.funct3;
          addr_d   = bus.addr;
          wdata_d  = bus.wdata[15:0];
          mem_wd_d = bus.wdata;
          if (illegal_s || misalign_s) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (!bus.we) begin
            state_d = READ;
          end else if (bus.funct3[1:0] == 2'b10) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (we_q) begin
          mem_wd_d = store_merge(funct3_q, addr_q[1:0], bus.mem_RD, wdata_q);
          state_d  = WRITE;
        end else begin
          rdata_d = load_extract(funct3_q, addr_q[1:0], bus.mem_RD);
          state_d = DONE;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    mem_we_d = (state_d == WRITE);
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'd0;
      wdata_q  <= 16'd0;
      rdata_q  <= 32'd0;
      mem_wd_q <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mem_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      mem_wd_q <= mem_wd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mem_we_q <= mem_we_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.rdata  = rdata_q;
  assign bus.mem_A  = {addr_q[31:2], 2'b00};
  assign bus.mem_WD = mem_wd_q;
  // a write must never land on a reset edge, even from the WRITE state
  assign bus.mem_WE = mem_we_q & ~rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural
// 64-word data memory.
module tb_load_store_unit;

  logic clk;
  logic rst;
  load_store_unit_if bus ();

  load_store_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  int          we_cnt = 0;
  logic [31:0] last_wa = 32'd0;
  int          n_checks = 0;
  int          n_fail = 0;

  assign bus.mem_RD = mem[bus.mem_A[7:2]];

  // data memory: synchronous write, counts write pulses
  always @(posedge clk) begin
    if (bus.mem_WE) begin
      mem[bus.mem_A[7:2]] <= bus.mem_WD;
      we_cnt  <= we_cnt + 1;
      last_wa <= bus.mem_A;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // issue one request from a negedge in IDLE; lat = edges from accept until
  // done is seen; returns in IDLE at a negedge
  task automatic do_op(input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output logic e,
                       output logic [31:0] rd);
    bus.req    = 1'b1;
    bus.we     = w;
    bus.funct3 = f;
    bus.addr   = a;
    bus.wdata  = d;
    @(negedge clk);
    bus.req = 1'b0;
    lat = 1;
    while (!bus.done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    e  = bus.err;
    rd = bus.rdata;
    @(negedge clk);
  endtask

  initial begin
    int          lat;
    logic        e;
    logic [31:0] rd;
    int          w0;

    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    rst        = 1'b1;
    bus.req    = 1'b0;
    bus.we     = 1'b0;
    bus.funct3 = 3'b000;
    bus.addr   = 32'd0;
    bus.wdata  = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy",   {31'd0, bus.busy},   32'd0);
    check("rst_done",   {31'd0, bus.done},   32'd0);
    check("rst_err",    {31'd0, bus.err},    32'd0);
    check("rst_we",     {31'd0, bus.mem_WE}, 32'd0);
    check("rst_rdata",  bus.rdata,           32'd0);
    check("rst_mem_a",  bus.mem_A,           32'd0);
    check("rst_mem_wd", bus.mem_WD,          32'd0);
    rst = 1'b0;
    @(negedge clk);

    // store word
    mem[5] = 32'd0;
    w0 = we_cnt;
    do_op(1'b1, 3'b010, 32'd20, 32'hDEADBEEF, lat, e, rd);
    check("sw_lat",    lat,           32'd2);
    check("sw_err",    {31'd0, e},    32'd0);
    check("sw_mem",    mem[5],        32'hDEADBEEF);
    check("sw_wecnt",  we_cnt - w0,   32'd1);
    check("sw_addr",   last_wa,       32'd20);

    // store byte (read-modify-write)
    mem[8] = 32'hCAFEBABE;
    w0 = we_cnt;
    do_op(1'b1, 3'b000, 32'd33, 32'h000000AA, lat, e, rd);
    check("sb_lat",    lat,           32'd3);
    check("sb_mem",    mem[8],        32'hCAFEAABE);
    check("sb_wecnt",  we_cnt - w0,   32'd1);
    check("sb_addr",   last_wa,       32'd32);

    // loads with extension
    mem[8] = 32'hCAFEBABE;
    w0 = we_cnt;
    do_op(1'b0, 3'b000, 32'd35, 32'd0, lat, e, rd);
    check("lb_lat",    lat, 32'd2);
    check("lb_rdata",  rd,  32'hFFFFFFCA);
    do_op(1'b0, 3'b100, 32'd35, 32'd0, lat, e, rd);
    check("lbu_rdata", rd,  32'h000000CA);
    do_op(1'b0, 3'b101, 32'd32, 32'd0, lat, e, rd);
    check("lhu_rdata", rd,  32'h0000BABE);
    do_op(1'b0, 3'b001, 32'd34, 32'd0, lat, e, rd);
    check("lh_rdata",  rd,  32'hFFFFCAFE);
    do_op(1'b0, 3'b010, 32'd32, 32'd0, lat, e, rd);
    check("lw_rdata",  rd,  32'hCAFEBABE);
    check("lw_err",    {31'd0, e}, 32'd0);
    check("ld_wecnt",  we_cnt - w0, 32'd0);

    // store halfword into upper half
    mem[9] = 32'h11223344;
    do_op(1'b1, 3'b001, 32'd38, 32'h00001234, lat, e, rd);
    check("sh_lat",    lat,    32'd3);
    check("sh_mem",    mem[9], 32'h12343344);

    // illegal funct3
    w0 = we_cnt;
    do_op(1'b0, 3'b011, 32'd32, 32'd0, lat, e, rd);
    check("ill_ld_lat",  lat,        32'd1);
    check("ill_ld_err",  {31'd0, e}, 32'd1);
    check("ill_ld_hold", rd,         32'hCAFEBABE);
    do_op(1'b1, 3'b100, 32'd36, 32'h0000FFFF, lat, e, rd);
    check("ill_st_lat",  lat,        32'd1);
    check("ill_st_err",  {31'd0, e}, 32'd1);
    check("ill_wecnt",   we_cnt - w0, 32'd0);
    check("ill_st_mem",  mem[9],     32'h12343344);

    // misaligned accesses
    w0 = we_cnt;
    do_op(1'b0, 3'b010, 32'd22, 32'd0, lat, e, rd);
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis_lw_lat", lat,        32'd1);
    check("mis_lw_err", {31'd0, e}, 32'd1);
`else
    check("mis_lw_lat",   lat,        32'd2);
    check("mis_lw_err",   {31'd0, e}, 32'd0);
    check("mis_lw_rdata", rd,         32'hDEADBEEF);
    do_op(1'b0, 3'b101, 32'd33, 32'd0, lat, e, rd);
    check("mis_lhu_rdata", rd,        32'h0000BABE);
`endif
    check("mis_wecnt", we_cnt - w0, 32'd0);

    // reset during WRITE of a halfword store
    mem[10] = 32'h55667788;
    w0 = we_cnt;
    bus.req    = 1'b1;
    bus.we     = 1'b1;
    bus.funct3 = 3'b001;
    bus.addr   = 32'd40;
    bus.wdata  = 32'h0000ABCD;
    @(negedge clk);
    bus.req = 1'b0;
    check("abort_read_busy", {31'd0, bus.busy},   32'd1);
    @(negedge clk);
    check("abort_in_write",  {31'd0, bus.mem_WE}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_we_gated",  {31'd0, bus.mem_WE}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",  {31'd0, bus.busy}, 32'd0);
    check("abort_done",  {31'd0, bus.done}, 32'd0);
    check("abort_mem",   mem[10],           32'h55667788);
    check("abort_wecnt", we_cnt - w0,       32'd0);
    do_op(1'b0, 3'b010, 32'd40, 32'd0, lat, e, rd);
    check("post_rst_lat",   lat, 32'd2);
    check("post_rst_rdata", rd,  32'h55667788);

    // req held high: second request only accepted from IDLE after DONE
    bus.req    = 1'b1;
    bus.we     = 1'b0;
    bus.funct3 = 3'b010;
    bus.addr   = 32'd20;
    @(negedge clk);
    check("hold_busy0", {31'd0, bus.busy}, 32'd1);
    check("hold_done0", {31'd0, bus.done}, 32'd0);
    bus.addr = 32'd32;
    @(negedge clk);
    check("hold_done1",  {31'd0, bus.done}, 32'd1);
    check("hold_rdata1", bus.rdata,         32'hDEADBEEF);
    @(negedge clk);
    check("hold_idle",   {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    check("hold_busy2",  {31'd0, bus.busy}, 32'd1);
    bus.req = 1'b0;
    @(negedge clk);
    check("hold_done2",  {31'd0, bus.done}, 32'd1);
    check("hold_rdata2", bus.rdata,         32'hCAFEBABE);
    @(negedge clk);
    check("final_idle",  {31'd0, bus.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
